// File: rtl/sha256_pad.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_pad (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [0:511] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
);

  typedef enum logic [1:0] {FILL, PAD, OUT, OUT2} state_t;

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [63:0]  len_q, len_d;
  logic [0:511] blk_q, blk_d;
  logic         last_q, last_d;
  logic         end_q, end_d;    // message ended; padding still owed or in flight
  logic         full_q, full_d;  // message ended exactly on a block boundary
  logic [8:0]   base;

  assign base      = {cnt_q[5:0], 3'b000};
  assign in_ready  = reset && (state_q == FILL);
  assign blk_valid = (state_q == OUT) || (state_q == OUT2);
  assign blk_last  = last_q;
  assign blk_data  = blk_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    blk_d   = blk_q;
    last_d  = last_q;
    end_d   = end_q;
    full_d  = full_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          blk_d[base +: 8] = in_data;
          cnt_d            = cnt_q + 7'd1;
          len_d            = len_q + 64'd8;
          if (in_last) begin
            end_d   = 1'b1;
            state_d = PAD;
          end else if (cnt_q == 7'd63) begin
            state_d = PAD;
          end
        end
      end

      PAD: begin
        state_d = OUT;
        if (end_q) begin
          if (cnt_q[6]) begin
            full_d = 1'b1;
          end else begin
            blk_d[base +: 8] = 8'h80;
            if (cnt_q <= 7'd55) begin
              blk_d[448 +: 64] = len_q;
              last_d           = 1'b1;
            end
          end
        end
      end

      OUT: begin
        if (blk_ready) begin
          blk_d = '0;
          if (end_q && !last_q) begin
            // Length did not fit: build the trailing block now.
            blk_d[0 +: 8]    = full_q ? 8'h80 : 8'h00;
            blk_d[448 +: 64] = len_q;
            last_d           = 1'b1;
            state_d          = OUT2;
          end else begin
            cnt_d   = '0;
            state_d = FILL;
            if (last_q) begin
              len_d  = '0;
              last_d = 1'b0;
              end_d  = 1'b0;
              full_d = 1'b0;
            end
          end
        end
      end

      OUT2: begin
        if (blk_ready) begin
          blk_d   = '0;
          cnt_d   = '0;
          len_d   = '0;
          last_d  = 1'b0;
          end_d   = 1'b0;
          full_d  = 1'b0;
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: the block buffer is reset along with control state because blk_data
  // is observable and must read zero during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      end_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      end_q   <= end_d;
      full_q  <= full_d;
    end
  end

endmodule
